// File: rtl/caxi4interconnect_dwc_precalc_achannel_fifo_pkg.sv
// Shared types and helpers for the DWC A-channel pre-calc FIFO and its calc block.
package caxi4interconnect_dwc_precalc_achannel_fifo_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Fixed-width AXI4 command attributes carried alongside ID/ADDR/USER
    typedef struct packed {
        logic [7:0] alen;
        logic [2:0] asize;
        logic [1:0] aburst;
        logic [3:0] acache;
        logic       alock;
        logic [2:0] aprot;
        logic [3:0] aqos;
        logic [3:0] aregion;
    } axi_ctrl_t;

    // Per-command pre-calculated width-conversion fields
    typedef struct packed {
        logic [8:0]  to_boundary;
        logic [11:0] mask_wrap;
        logic [3:0]  size_diff;
        logic [7:0]  len_offset;
        logic [7:0]  len_first;
        logic [7:0]  len_second;
        logic        wrap_tx;
        logic        fixed;
        logic        size_err;
        logic        cross_4k;
    } precalc_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/caxi4interconnect_dwc_precalc_achannel_fifo_calc.sv
// Combinational WRAP-split / size-ratio / offset calculation for one AXI command.
// Optional 4KB-crossing flag enabled by DWC_PRECALC_4K_CHECK_EN.
module caxi4interconnect_dwc_precalc_calc
    import caxi4interconnect_dwc_precalc_achannel_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 64,
    parameter int unsigned DATA_WIDTH_OUT = 64,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic [ADDR_WIDTH-1:0] aaddr,
    input  logic [7:0]            alen,
    input  logic [2:0]            asize,
    input  logic [1:0]            aburst,
    output precalc_t              rec_c
);

    localparam int unsigned IN_LOG    = clog2(DATA_WIDTH_IN / 8);
    localparam int unsigned OUT_LOG   = clog2(DATA_WIDTH_OUT / 8);
    localparam int unsigned OUT_BYTES = DATA_WIDTH_OUT / 8;

    logic                  is_wrap;
    logic [7:0]            addr_beat;
    logic [15:0]           total_bytes;
    logic [ADDR_WIDTH-1:0] out_offset;

    always_comb begin
        rec_c       = '0;
        is_wrap     = (aburst == BURST_WRAP);
        total_bytes = (16'(alen) + 16'd1) << asize;
        addr_beat   = 8'(aaddr >> asize) & {4'h0, alen[3:0]};
        out_offset  = aaddr & ADDR_WIDTH'(OUT_BYTES - 1);

        rec_c.to_boundary = is_wrap ? 9'(alen) + 9'd1 - 9'(addr_beat) : 9'(alen) + 9'd1;
        rec_c.mask_wrap   = 12'(total_bytes - 16'd1);
        rec_c.wrap_tx     = is_wrap && ((aaddr[11:0] & rec_c.mask_wrap) != 12'd0);
        if (OUT_LOG > 32'(asize)) rec_c.size_diff = 4'(OUT_LOG - 32'(asize));
        rec_c.len_offset  = 8'(out_offset >> asize);
        rec_c.len_first   = 8'((rec_c.to_boundary - 9'd1) >> rec_c.size_diff);
        // Second part only exists when the wrap has to be split in two
        if (rec_c.wrap_tx) rec_c.len_second = 8'((9'(alen) - rec_c.to_boundary) >> rec_c.size_diff);
        rec_c.fixed       = (aburst == BURST_FIXED);
        rec_c.size_err    = (32'(asize) > IN_LOG);
`ifdef DWC_PRECALC_4K_CHECK_EN
        rec_c.cross_4k    = (aburst == BURST_INCR) &&
                            ((17'(aaddr[11:0]) + 17'(total_bytes)) > 17'd4096);
`else
        rec_c.cross_4k    = 1'b0;
`endif
    end

endmodule

// File: rtl/caxi4interconnect_dwc_precalc_achannel_fifo.sv
// DEPTH-entry A-channel FIFO storing each command with its pre-calculated DWC fields.
// m_4k_cross is live only when DWC_PRECALC_4K_CHECK_EN is defined.
module caxi4interconnect_dwc_precalc_achannel_fifo
    import caxi4interconnect_dwc_precalc_achannel_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 64,
    parameter int unsigned DATA_WIDTH_OUT = 64,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned DEPTH          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_avalid,
    output logic                  s_aready,
    input  logic [ID_WIDTH-1:0]   s_aid,
    input  logic [ADDR_WIDTH-1:0] s_aaddr,
    input  logic [7:0]            s_alen,
    input  logic [2:0]            s_asize,
    input  logic [1:0]            s_aburst,
    input  logic [3:0]            s_acache,
    input  logic                  s_alock,
    input  logic [2:0]            s_aprot,
    input  logic [3:0]            s_aqos,
    input  logic [3:0]            s_aregion,
    input  logic [USER_WIDTH-1:0] s_auser,
    output logic                  m_avalid,
    input  logic                  m_aready,
    output logic [ID_WIDTH-1:0]   m_aid,
    output logic [ADDR_WIDTH-1:0] m_aaddr,
    output logic [7:0]            m_alen,
    output logic [2:0]            m_asize,
    output logic [1:0]            m_aburst,
    output logic [3:0]            m_acache,
    output logic                  m_alock,
    output logic [2:0]            m_aprot,
    output logic [3:0]            m_aqos,
    output logic [3:0]            m_aregion,
    output logic [USER_WIDTH-1:0] m_auser,
    output logic [8:0]            m_to_boundary,
    output logic [11:0]           m_mask_wrap,
    output logic [3:0]            m_size_diff,
    output logic [7:0]            m_len_offset,
    output logic [7:0]            m_len_first,
    output logic [7:0]            m_len_second,
    output logic                  m_wrap_tx,
    output logic                  m_fixed,
    output logic                  m_size_err,
    output logic                  m_4k_cross,
    output logic [clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [USER_WIDTH-1:0] mem_user [DEPTH];
    axi_ctrl_t             mem_ctrl [DEPTH];
    precalc_t              mem_rec  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt_c;
    logic [CNT_W-1:0]      count_nxt_c;
    logic                  push_c, pop_c, bypass_c;
    axi_ctrl_t             s_ctrl_c, head_ctrl_c, m_ctrl;
    precalc_t              s_rec_c, head_rec_c, m_rec;
    logic [ID_WIDTH-1:0]   head_id_c;
    logic [ADDR_WIDTH-1:0] head_addr_c;
    logic [USER_WIDTH-1:0] head_user_c;

    assign s_ctrl_c = '{alen: s_alen, asize: s_asize, aburst: s_aburst, acache: s_acache,
                        alock: s_alock, aprot: s_aprot, aqos: s_aqos, aregion: s_aregion};

    caxi4interconnect_dwc_precalc_calc #(
        .DATA_WIDTH_IN  (DATA_WIDTH_IN),
        .DATA_WIDTH_OUT (DATA_WIDTH_OUT),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_calc (
        .aaddr  (s_aaddr),
        .alen   (s_alen),
        .asize  (s_asize),
        .aburst (s_aburst),
        .rec_c  (s_rec_c)
    );

    // Handshakes and next pointer/occupancy
    always_comb begin
        push_c       = s_avalid && s_aready;
        pop_c        = m_avalid && m_aready;
        rd_ptr_nxt_c = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt_c  = count + CNT_W'(push_c) - CNT_W'(pop_c);
        // Incoming command becomes the head when it lands in the next read slot
        bypass_c     = push_c && (wr_ptr == rd_ptr_nxt_c);
    end

    // Next head entry, forwarded from the input when written this cycle
    always_comb begin
        head_id_c   = mem_id[rd_ptr_nxt_c];
        head_addr_c = mem_addr[rd_ptr_nxt_c];
        head_user_c = mem_user[rd_ptr_nxt_c];
        head_ctrl_c = mem_ctrl[rd_ptr_nxt_c];
        head_rec_c  = mem_rec[rd_ptr_nxt_c];
        if (bypass_c) begin
            head_id_c   = s_aid;
            head_addr_c = s_aaddr;
            head_user_c = s_auser;
            head_ctrl_c = s_ctrl_c;
            head_rec_c  = s_rec_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_id[wr_ptr]   <= s_aid;
            mem_addr[wr_ptr] <= s_aaddr;
            mem_user[wr_ptr] <= s_auser;
            mem_ctrl[wr_ptr] <= s_ctrl_c;
            mem_rec[wr_ptr]  <= s_rec_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            s_aready <= 1'b0;
            m_avalid <= 1'b0;
            m_aid    <= '0;
            m_aaddr  <= '0;
            m_auser  <= '0;
            m_ctrl   <= '0;
            m_rec    <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr   <= rd_ptr_nxt_c;
            count    <= count_nxt_c;
            s_aready <= (count_nxt_c != CNT_W'(DEPTH));
            m_avalid <= (count_nxt_c != '0);
            m_aid    <= head_id_c;
            m_aaddr  <= head_addr_c;
            m_auser  <= head_user_c;
            m_ctrl   <= head_ctrl_c;
            m_rec    <= head_rec_c;
        end
    end

    assign m_alen        = m_ctrl.alen;
    assign m_asize       = m_ctrl.asize;
    assign m_aburst      = m_ctrl.aburst;
    assign m_acache      = m_ctrl.acache;
    assign m_alock       = m_ctrl.alock;
    assign m_aprot       = m_ctrl.aprot;
    assign m_aqos        = m_ctrl.aqos;
    assign m_aregion     = m_ctrl.aregion;
    assign m_to_boundary = m_rec.to_boundary;
    assign m_mask_wrap   = m_rec.mask_wrap;
    assign m_size_diff   = m_rec.size_diff;
    assign m_len_offset  = m_rec.len_offset;
    assign m_len_first   = m_rec.len_first;
    assign m_len_second  = m_rec.len_second;
    assign m_wrap_tx     = m_rec.wrap_tx;
    assign m_fixed       = m_rec.fixed;
    assign m_size_err    = m_rec.size_err;
    assign m_4k_cross    = m_rec.cross_4k;

endmodule

// File: tb/tb_caxi4interconnect_dwc_precalc_achannel_fifo.sv
// Scoreboard bench for the DWC A-channel pre-calc FIFO (64-bit in/out, DEPTH=2).
`timescale 1ns/1ps
module tb_caxi4interconnect_dwc_precalc_achannel_fifo;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
        logic        lock;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } cmd_t;

    typedef struct packed {
        cmd_t        cmd;
        logic [8:0]  to_b;
        logic [11:0] mask;
        logic [3:0]  sd;
        logic [7:0]  lo;
        logic [7:0]  lf;
        logic [7:0]  ls;
        logic        wtx;
        logic        fixed;
        logic        serr;
        logic        x4k;
    } exp_t;

`ifdef DWC_PRECALC_4K_CHECK_EN
    localparam logic EXP_4K = 1'b1;
`else
    localparam logic EXP_4K = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_avalid, s_aready, m_avalid, m_aready;
    logic [3:0]  s_aid, m_aid, s_acache, m_acache, s_aqos, m_aqos, s_aregion, m_aregion;
    logic [31:0] s_aaddr, m_aaddr;
    logic [7:0]  s_alen, m_alen;
    logic [2:0]  s_asize, m_asize, s_aprot, m_aprot;
    logic [1:0]  s_aburst, m_aburst;
    logic        s_alock, m_alock;
    logic [0:0]  s_auser, m_auser;
    logic [8:0]  m_to_boundary;
    logic [11:0] m_mask_wrap;
    logic [3:0]  m_size_diff;
    logic [7:0]  m_len_offset, m_len_first, m_len_second;
    logic        m_wrap_tx, m_fixed, m_size_err, m_4k_cross;
    logic [1:0]  count;

    exp_t sb[$];
    exp_t exp_e, act_e;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    caxi4interconnect_dwc_precalc_achannel_fifo #(
        .DATA_WIDTH_IN(64), .DATA_WIDTH_OUT(64), .ADDR_WIDTH(32),
        .ID_WIDTH(4), .USER_WIDTH(1), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_avalid(s_avalid), .s_aready(s_aready),
        .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize),
        .s_aburst(s_aburst), .s_acache(s_acache), .s_alock(s_alock), .s_aprot(s_aprot),
        .s_aqos(s_aqos), .s_aregion(s_aregion), .s_auser(s_auser),
        .m_avalid(m_avalid), .m_aready(m_aready),
        .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize),
        .m_aburst(m_aburst), .m_acache(m_acache), .m_alock(m_alock), .m_aprot(m_aprot),
        .m_aqos(m_aqos), .m_aregion(m_aregion), .m_auser(m_auser),
        .m_to_boundary(m_to_boundary), .m_mask_wrap(m_mask_wrap), .m_size_diff(m_size_diff),
        .m_len_offset(m_len_offset), .m_len_first(m_len_first), .m_len_second(m_len_second),
        .m_wrap_tx(m_wrap_tx), .m_fixed(m_fixed), .m_size_err(m_size_err),
        .m_4k_cross(m_4k_cross), .count(count)
    );

    // Reference model for a 64-bit output bus (8-byte words)
    function automatic exp_t model(input cmd_t c);
        exp_t        e;
        int unsigned a, beats, bytes, mask, abeat, tb, sd;
        logic        is_wrap;
        a       = c.addr;
        is_wrap = (c.burst == 2'b10);
        beats   = 32'(c.len) + 1;
        bytes   = beats << c.size;
        mask    = (bytes - 1) & 32'hFFF;
        abeat   = (a >> c.size) & (32'(c.len) & 32'hF);
        tb      = is_wrap ? beats - abeat : beats;
        sd      = (32'(c.size) < 3) ? 3 - 32'(c.size) : 0;
        e.cmd   = c;
        e.to_b  = 9'(tb);
        e.mask  = 12'(mask);
        e.wtx   = is_wrap && ((a & mask) != 0);
        e.sd    = 4'(sd);
        e.lo    = 8'((a % 8) >> c.size);
        e.lf    = 8'((tb - 1) >> sd);
        e.ls    = e.wtx ? 8'((32'(c.len) - tb) >> sd) : 8'd0;
        e.fixed = (c.burst == 2'b00);
        e.serr  = (32'(c.size) > 3);
        e.x4k   = EXP_4K && (c.burst == 2'b01) && (((a & 32'hFFF) + bytes) > 4096);
        return e;
    endfunction

    function automatic cmd_t rand_cmd(input logic [1:0] burst);
        cmd_t c;
        c.id     = 4'($urandom);
        c.size   = 3'($urandom_range(0, 3));
        c.burst  = burst;
        c.len    = (burst == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1)
                 : (burst == 2'b00) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        c.addr   = $urandom;
        c.addr   = (c.addr >> c.size) << c.size;
        c.cache  = 4'($urandom);
        c.lock   = 1'($urandom);
        c.prot   = 3'($urandom);
        c.qos    = 4'($urandom);
        c.region = 4'($urandom);
        c.user   = 1'($urandom);
        return c;
    endfunction

    task automatic set_cmd(input cmd_t c);
        s_aid = c.id; s_aaddr = c.addr; s_alen = c.len; s_asize = c.size; s_aburst = c.burst;
        s_acache = c.cache; s_alock = c.lock; s_aprot = c.prot; s_aqos = c.qos;
        s_aregion = c.region; s_auser = c.user;
    endtask

    task automatic push_one(input cmd_t c);
        @(posedge clk); #1;
        set_cmd(c);
        s_avalid = 1'b1;
        @(posedge clk); #1;
        s_avalid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        s_avalid = 1'b0;
        m_aready = 1'b1;
        for (int i = 0; i < 20 && count !== 2'd0; i++) @(negedge clk);
        total++;
        if (count !== 2'd0) $display("FAIL drain_timeout count=%0d want 0", count);
        else passed++;
    endtask

    // Scoreboard: record accepted commands, compare each popped head
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            if (m_avalid && m_aready) begin
                total++;
                act_e = {m_aid, m_aaddr, m_alen, m_asize, m_aburst, m_acache, m_alock, m_aprot,
                         m_aqos, m_aregion, m_auser, m_to_boundary, m_mask_wrap, m_size_diff,
                         m_len_offset, m_len_first, m_len_second, m_wrap_tx, m_fixed,
                         m_size_err, m_4k_cross};
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected got=%h want none", act_e);
                end else begin
                    exp_e = sb.pop_front();
                    if (act_e !== exp_e) $display("FAIL sb_entry got=%h want=%h", act_e, exp_e);
                    else passed++;
                end
            end
            if (s_avalid && s_aready)
                sb.push_back(model({s_aid, s_aaddr, s_alen, s_asize, s_aburst, s_acache,
                                    s_alock, s_aprot, s_aqos, s_aregion, s_auser}));
        end
    end

    task automatic test_reset();
        rst = 1'b0; s_avalid = 1'b0; m_aready = 1'b0;
        set_cmd('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (m_avalid !== 1'b0) $display("FAIL rst_m_avalid got=%b want 0", m_avalid); else passed++;
        total++; if (s_aready !== 1'b0) $display("FAIL rst_s_aready got=%b want 0", s_aready); else passed++;
        total++; if (count !== 2'd0) $display("FAIL rst_count got=%0d want 0", count); else passed++;
        total++;
        if ({m_aaddr, m_to_boundary, m_len_first} !== '0)
            $display("FAIL rst_fields got=%h want 0", {m_aaddr, m_to_boundary, m_len_first});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (s_aready !== 1'b1) $display("FAIL rst_release_s_aready got=%b want 1", s_aready); else passed++;
    endtask

    task automatic test_wrap();
        cmd_t c;
        c = '0; c.id = 4'h5; c.addr = 32'h0C; c.len = 8'd3; c.size = 3'd2; c.burst = 2'b10;
        m_aready = 1'b1;
        push_one(c);
        @(negedge clk);
        total++; if (m_avalid !== 1'b1) $display("FAIL wrap_latency got=%b want 1", m_avalid); else passed++;
        total++; if (m_to_boundary !== 9'd1) $display("FAIL wrap_to_boundary got=%0d want 1", m_to_boundary); else passed++;
        total++; if (m_mask_wrap !== 12'h00F) $display("FAIL wrap_mask got=%h want 00f", m_mask_wrap); else passed++;
        total++; if (m_wrap_tx !== 1'b1) $display("FAIL wrap_tx got=%b want 1", m_wrap_tx); else passed++;
        total++; if (m_size_diff !== 4'd1) $display("FAIL wrap_size_diff got=%0d want 1", m_size_diff); else passed++;
        total++; if (m_len_offset !== 8'd1) $display("FAIL wrap_len_offset got=%0d want 1", m_len_offset); else passed++;
        total++; if (m_len_first !== 8'd0) $display("FAIL wrap_len_first got=%0d want 0", m_len_first); else passed++;
        total++; if (m_len_second !== 8'd1) $display("FAIL wrap_len_second got=%0d want 1", m_len_second); else passed++;
    endtask

    task automatic test_incr();
        cmd_t c;
        c = '0; c.id = 4'hA; c.addr = 32'h100; c.len = 8'd7; c.size = 3'd3; c.burst = 2'b01;
        push_one(c);
        @(negedge clk);
        total++; if (m_to_boundary !== 9'd8) $display("FAIL incr_to_boundary got=%0d want 8", m_to_boundary); else passed++;
        total++; if (m_wrap_tx !== 1'b0) $display("FAIL incr_wrap_tx got=%b want 0", m_wrap_tx); else passed++;
        total++; if (m_size_diff !== 4'd0) $display("FAIL incr_size_diff got=%0d want 0", m_size_diff); else passed++;
        total++; if (m_len_first !== 8'd7) $display("FAIL incr_len_first got=%0d want 7", m_len_first); else passed++;
        total++; if (m_len_second !== 8'd0) $display("FAIL incr_len_second got=%0d want 0", m_len_second); else passed++;
        total++; if (m_fixed !== 1'b0) $display("FAIL incr_fixed got=%b want 0", m_fixed); else passed++;
    endtask

    task automatic test_boundaries();
        cmd_t c;
        c = '0; c.addr = 32'hFC0; c.len = 8'd15; c.size = 3'd3; c.burst = 2'b01;
        push_one(c);
        @(negedge clk);
        total++; if (m_4k_cross !== EXP_4K) $display("FAIL cross_4k got=%b want %b", m_4k_cross, EXP_4K); else passed++;
        c.addr = 32'hF80;
        push_one(c);
        @(negedge clk);
        total++; if (m_4k_cross !== 1'b0) $display("FAIL cross_4k_exact got=%b want 0", m_4k_cross); else passed++;
        c.size = 3'd4; c.burst = 2'b00; c.len = 8'd0; c.addr = 32'h30;
        push_one(c);
        @(negedge clk);
        total++; if (m_size_err !== 1'b1) $display("FAIL size_err got=%b want 1", m_size_err); else passed++;
        total++; if (m_fixed !== 1'b1) $display("FAIL fixed got=%b want 1", m_fixed); else passed++;
        c.size = 3'd0; c.len = 8'd255; c.burst = 2'b01; c.addr = 32'h7;
        push_one(c);
        @(negedge clk);
        total++; if (m_to_boundary !== 9'd256) $display("FAIL len256_to_boundary got=%0d want 256", m_to_boundary); else passed++;
    endtask

    task automatic test_fill();
        @(posedge clk); #1;
        m_aready = 1'b0;
        set_cmd(rand_cmd(2'b01));
        s_avalid = 1'b1;
        @(posedge clk); #1;
        set_cmd(rand_cmd(2'b10));
        @(posedge clk); #1;
        set_cmd(rand_cmd(2'b00));
        @(negedge clk);
        total++; if (s_aready !== 1'b0) $display("FAIL full_s_aready got=%b want 0", s_aready); else passed++;
        total++; if (count !== 2'd2) $display("FAIL full_count got=%0d want 2", count); else passed++;
        @(posedge clk); #1;
        m_aready = 1'b1;
        @(posedge clk); #1;
        m_aready = 1'b0;
        @(negedge clk);
        total++; if (count !== 2'd1) $display("FAIL full_pop_no_push count=%0d want 1", count); else passed++;
        total++; if (s_aready !== 1'b1) $display("FAIL full_ready_rise got=%b want 1", s_aready); else passed++;
        @(posedge clk); #1;
        s_avalid = 1'b0;
        @(negedge clk);
        total++; if (count !== 2'd2) $display("FAIL full_refill count=%0d want 2", count); else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        m_aready = 1'b0;
        set_cmd(rand_cmd(2'b01));
        s_avalid = 1'b1;
        @(posedge clk); #1;
        m_aready = 1'b1;
        set_cmd(rand_cmd(2'b10));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (count !== 2'd1 || m_avalid !== 1'b1 || s_aready !== 1'b1) bad++;
            @(posedge clk); #1;
            set_cmd(rand_cmd(2'($urandom_range(0, 2))));
        end
        s_avalid = 1'b0;
        total++; if (bad != 0) $display("FAIL b2b_steady bad_cycles=%0d want 0", bad); else passed++;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            s_avalid = 1'($urandom_range(0, 1));
            m_aready = 1'($urandom_range(0, 1));
            set_cmd(rand_cmd(2'($urandom_range(0, 2))));
        end
        drain();
        total++; if (sb.size() != 0) $display("FAIL random_leftover got=%0d want 0", sb.size()); else passed++;
    endtask

    task automatic test_mid_reset();
        cmd_t c;
        @(posedge clk); #1;
        m_aready = 1'b0;
        set_cmd(rand_cmd(2'b01));
        s_avalid = 1'b1;
        @(posedge clk); #1;
        set_cmd(rand_cmd(2'b01));
        @(posedge clk); #1;
        s_avalid = 1'b0;
        @(negedge clk);
        total++; if (count !== 2'd2) $display("FAIL mrst_pre_count got=%0d want 2", count); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (m_avalid !== 1'b0) $display("FAIL mrst_m_avalid got=%b want 0", m_avalid); else passed++;
        total++; if (count !== 2'd0) $display("FAIL mrst_count got=%0d want 0", count); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        m_aready = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (m_avalid !== 1'b0) $display("FAIL mrst_stale got=%b want 0", m_avalid); else passed++;
        c = rand_cmd(2'b10);
        c.id = 4'h9;
        push_one(c);
        @(negedge clk);
        total++; if (m_aid !== 4'h9) $display("FAIL mrst_new_id got=%h want 9", m_aid); else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_incr();
        test_boundaries();
        test_fill();
        test_back_to_back();
        test_random();
        test_mid_reset();
        total++;
        if (sb.size() != 0) $display("FAIL final_leftover got=%0d want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t want finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
